pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage directly downstream of the control block.
- Consumes the registered branch, jump and immType strobes together with the register-file operands.
- Resolves taken or not-taken, redirects the fetch PC, and issues a one-cycle flush that squashes the wrong-path instruction.
- Owns the only PC register in the core; instruction memory is addressed from its pc output.

Parameters:
- PC_WIDTH, 16, width of pc, instr_pc and target arithmetic.
- DATA_WIDTH, 16, width of the rs_val/rt_val operands, compared as two's-complement signed.
- OFF_WIDTH, 8, width of imm_offset, sign-extended to PC_WIDTH.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold pc; no fetch advance.
- instr_valid  in  1  the strobes and operands below belong to a live instruction at instr_pc.
- instr_pc  in  PC_WIDTH  address of that instruction.
- branchEq, branchNeq, branchLt, branchGt, branchLte, branchGte  in  1 each  branch-type strobes.
- jump  in  1  unconditional jump.
- immType  in  1  with jump: 1 = pc-relative immediate, 0 = register target.
- rs_val, rt_val  in  DATA_WIDTH  compare operands; rs_val[PC_WIDTH-1:0] is the register-jump target.
- imm_offset  in  OFF_WIDTH  signed branch/jump offset.
- pc  out  PC_WIDTH  fetch address.
- fetch_valid  out  1  pc is a live fetch this cycle.
- flush  out  1  one-cycle pulse; squash the in-flight instruction.
- taken  out  1  registered; last resolved instruction redirected.
- multi_err  out  1  sticky; more than one strobe seen in the same cycle.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, fetch_valid=0, flush=0, taken=0, multi_err=0, state=BOOT. Reset mid-FLUSH abandons the redirect.
- States: BOOT, RUN, FLUSH. All outputs are registered.
- BOOT: lasts exactly one cycle after reset deasserts. fetch_valid=0, pc held, then go to RUN. Inputs are ignored.
- RUN, instr_valid=1 with the instruction taken:
  - pc <= target; flush <= 1 for one cycle; taken <= 1; go to FLUSH.
  - A redirect overrides stall.
- RUN, not taken or instr_valid=0:
  - stall=1: hold pc.
  - Otherwise pc <= pc+1.
  - flush <= 0. taken updates only when instr_valid=1 (<= 0).
- FLUSH: lasts one cycle.
  - fetch_valid=1 while fetching the target.
  - instr_valid is ignored, because it carries the squashed wrong-path instruction.
  - pc <= pc+1 unless stall; go to RUN.
- fetch_valid = (state != BOOT) && !stall.
- Taken conditions, all signed compares of rs_val against rt_val:
  - Eq: rs==rt. Neq: rs!=rt.
  - Lt: rs<rt. Gt: rs>rt.
  - Lte: rs<=rt. Gte: rs>=rt.
  - jump: always taken.
- Targets, all arithmetic modulo 2^PC_WIDTH (wrap-around, no error):
  - Branch, and jump with immType=1: instr_pc + sext(imm_offset).
  - Jump with immType=0: rs_val[PC_WIDTH-1:0].
- Multiple strobes in one valid cycle:
  - Priority is jump > Eq > Neq > Lt > Gt > Lte > Gte.
  - multi_err sets and stays set until reset.
- pc+1 at all-ones wraps to 0.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- When defined, add two outputs, br_taken_cnt and br_ntaken_cnt, 16 bits each.
  - They count resolved conditional branches only; jumps are excluded.
  - They saturate at 0xFFFF and clear on reset.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - State enum PCB_BOOT/PCB_RUN/PCB_FLUSH.
  - PC_WIDTH and DATA_WIDTH defaults.
  - Branch-kind encoding used by the priority encoder.
- One sub-module, branch_compare: purely combinational. Takes the strobes and operands; produces take and sel_reg_target plus the priority and multi-hot detect.

Test Plan:
- Reset released -> one cycle with fetch_valid=0 and pc=0, then pc=0,1,2,3 on successive cycles with fetch_valid=1.
- branchEq, rs=5, rt=5, instr_pc=0x0010, imm_offset=0xFC (-4) -> next pc=0x000C, flush pulses once, the following instr_valid is ignored, then pc=0x000D.
- branchLt, rs=0xFFFF (-1), rt=1 -> taken; branchGt on the same operands -> not taken, pc increments, taken=0.
- jump, immType=0, rs=0x1234 while stall=1 -> pc=0x1234, redirect overrides stall; jump with immType=1, instr_pc=0xFFFE, offset=0x05 -> pc=0x0003 (wrap).
- branchEq and branchNeq together with rs!=rt -> Eq priority gives not taken, multi_err=1 and stays 1 until reset.
- Reset asserted during FLUSH -> pc=RESET_PC, flush=0, taken=0 immediately (async); with PC_BRANCH_STATS_EN defined, 3 taken and 2 not-taken branches -> counters read 3 and 2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the PC/branch stage: FSM states, branch kinds
// and a multi-hot helper used by the branch priority encoder.
package cpu_pkg;

   localparam int PC_WIDTH_DEF   = 16;
   localparam int DATA_WIDTH_DEF = 16;
   localparam int N_STROBES      = 7;

   typedef enum logic [1:0] {
      PCB_BOOT  = 2'd0,
      PCB_RUN   = 2'd1,
      PCB_FLUSH = 2'd2
   } pcbState_e;

   // Listed in resolution priority order, highest first after BK_NONE.
   typedef enum logic [2:0] {
      BK_NONE = 3'd0,
      BK_JUMP = 3'd1,
      BK_EQ   = 3'd2,
      BK_NEQ  = 3'd3,
      BK_LT   = 3'd4,
      BK_GT   = 3'd5,
      BK_LTE  = 3'd6,
      BK_GTE  = 3'd7
   } brKind_e;

   function automatic logic isMultiHot(input logic [N_STROBES-1:0] vec);
      return |(vec & (vec - 7'd1));
   endfunction

endpackage

// File: rtl/pc_branch_unit_branch_compare.sv
// Combinational branch resolution: priority-encodes the strobes, evaluates the
// signed compare for the winning kind and flags simultaneous strobes.
module branch_compare
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  jump,
   input  logic                  immType,
   input  logic                  branchEq,
   input  logic                  branchNeq,
   input  logic                  branchLt,
   input  logic                  branchGt,
   input  logic                  branchLte,
   input  logic                  branchGte,
   input  logic [DATA_WIDTH-1:0] rsVal,
   input  logic [DATA_WIDTH-1:0] rtVal,
   output logic                  take,
   output logic                  selRegTarget,
   output logic                  multiHot,
   output brKind_e               kind
);

   logic signed [DATA_WIDTH-1:0] rsSigned_s;
   logic signed [DATA_WIDTH-1:0] rtSigned_s;
   logic [N_STROBES-1:0]         strobes_s;

   assign rsSigned_s = rsVal;
   assign rtSigned_s = rtVal;
   assign strobes_s  = {jump, branchEq, branchNeq, branchLt, branchGt, branchLte, branchGte};
   assign multiHot   = isMultiHot(strobes_s);

   // Priority encoder: jump > Eq > Neq > Lt > Gt > Lte > Gte
   always_comb begin
      kind = BK_NONE;
      if (jump) begin
         kind = BK_JUMP;
      end else if (branchEq) begin
         kind = BK_EQ;
      end else if (branchNeq) begin
         kind = BK_NEQ;
      end else if (branchLt) begin
         kind = BK_LT;
      end else if (branchGt) begin
         kind = BK_GT;
      end else if (branchLte) begin
         kind = BK_LTE;
      end else if (branchGte) begin
         kind = BK_GTE;
      end else begin
         kind = BK_NONE;
      end
   end

   // Outcome of the winning kind and register-target select
   always_comb begin
      take         = 1'b0;
      selRegTarget = (kind == BK_JUMP) && !immType;
      case (kind)
         BK_JUMP: take = 1'b1;
         BK_EQ:   take = (rsSigned_s == rtSigned_s);
         BK_NEQ:  take = (rsSigned_s != rtSigned_s);
         BK_LT:   take = (rsSigned_s <  rtSigned_s);
         BK_GT:   take = (rsSigned_s >  rtSigned_s);
         BK_LTE:  take = (rsSigned_s <= rtSigned_s);
         BK_GTE:  take = (rsSigned_s >= rtSigned_s);
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution stage; owns the fetch PC and issues the
// wrong-path flush. Optional branch statistics under PC_BRANCH_STATS_EN.
module pc_branch_unit
   import cpu_pkg::*;
#(
   parameter int                PC_WIDTH   = PC_WIDTH_DEF,
   parameter int                DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int                OFF_WIDTH  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  instr_valid,
   input  logic [PC_WIDTH-1:0]   instr_pc,
   input  logic                  branchEq,
   input  logic                  branchNeq,
   input  logic                  branchLt,
   input  logic                  branchGt,
   input  logic                  branchLte,
   input  logic                  branchGte,
   input  logic                  jump,
   input  logic                  immType,
   input  logic [DATA_WIDTH-1:0] rs_val,
   input  logic [DATA_WIDTH-1:0] rt_val,
   input  logic [OFF_WIDTH-1:0]  imm_offset,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  fetch_valid,
   output logic                  flush,
   output logic                  taken,
   output logic                  multi_err
`ifdef PC_BRANCH_STATS_EN
  ,output logic [15:0]           br_taken_cnt,
   output logic [15:0]           br_ntaken_cnt
`endif
);

   pcbState_e           state_r, stateNext_s;
   logic [PC_WIDTH-1:0] pc_r, pcNext_s, pcInc_s, target_s;
   logic                fetchValid_r, fetchValidNext_s;
   logic                flush_r, flushNext_s;
   logic                taken_r, takenNext_s;
   logic                multiErr_r, multiErrNext_s;
   logic                take_s, selRegTarget_s, multiHot_s;
   logic                resolveNow_s;
   brKind_e             kind_s;

   branch_compare #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_branch_compare (
      .jump         (jump),
      .immType      (immType),
      .branchEq     (branchEq),
      .branchNeq    (branchNeq),
      .branchLt     (branchLt),
      .branchGt     (branchGt),
      .branchLte    (branchLte),
      .branchGte    (branchGte),
      .rsVal        (rs_val),
      .rtVal        (rt_val),
      .take         (take_s),
      .selRegTarget (selRegTarget_s),
      .multiHot     (multiHot_s),
      .kind         (kind_s)
   );

   assign pcInc_s      = pc_r + PC_WIDTH'(1);
   assign target_s     = selRegTarget_s ? rs_val[PC_WIDTH-1:0]
                       : instr_pc + {{(PC_WIDTH-OFF_WIDTH){imm_offset[OFF_WIDTH-1]}}, imm_offset};
   assign resolveNow_s = (state_r == PCB_RUN) && instr_valid;

   // Next-state and next-output logic; in FLUSH the squashed instruction is ignored
   always_comb begin
      stateNext_s      = state_r;
      pcNext_s         = pc_r;
      fetchValidNext_s = 1'b0;
      flushNext_s      = 1'b0;
      takenNext_s      = taken_r;
      multiErrNext_s   = multiErr_r;
      case (state_r)
         PCB_BOOT: begin
            stateNext_s      = PCB_RUN;
            fetchValidNext_s = !stall;
         end
         PCB_RUN: begin
            if (resolveNow_s) begin
               takenNext_s    = take_s;
               multiErrNext_s = multiErr_r | multiHot_s;
            end else begin
               takenNext_s    = taken_r;
               multiErrNext_s = multiErr_r;
            end
            // A redirect wins over stall so the target is always fetched
            if (resolveNow_s && take_s) begin
               pcNext_s         = target_s;
               flushNext_s      = 1'b1;
               fetchValidNext_s = 1'b1;
               stateNext_s      = PCB_FLUSH;
            end else begin
               pcNext_s         = stall ? pc_r : pcInc_s;
               fetchValidNext_s = !stall;
               stateNext_s      = PCB_RUN;
            end
         end
         PCB_FLUSH: begin
            pcNext_s         = stall ? pc_r : pcInc_s;
            fetchValidNext_s = !stall;
            stateNext_s      = PCB_RUN;
         end
         default: begin
            stateNext_s = PCB_BOOT;
            pcNext_s    = RESET_PC;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r      <= PCB_BOOT;
         pc_r         <= RESET_PC;
         fetchValid_r <= 1'b0;
         flush_r      <= 1'b0;
         taken_r      <= 1'b0;
         multiErr_r   <= 1'b0;
      end else begin
         state_r      <= stateNext_s;
         pc_r         <= pcNext_s;
         fetchValid_r <= fetchValidNext_s;
         flush_r      <= flushNext_s;
         taken_r      <= takenNext_s;
         multiErr_r   <= multiErrNext_s;
      end
   end

   assign pc          = pc_r;
   assign fetch_valid = fetchValid_r;
   assign flush       = flush_r;
   assign taken       = taken_r;
   assign multi_err   = multiErr_r;

`ifdef PC_BRANCH_STATS_EN
   logic        condResolve_s;
   logic [15:0] brTakenCnt_r, brNtakenCnt_r;

   assign condResolve_s = resolveNow_s && (kind_s != BK_NONE) && (kind_s != BK_JUMP);

   // Saturating counters of resolved conditional branches
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         brTakenCnt_r  <= 16'd0;
         brNtakenCnt_r <= 16'd0;
      end else if (condResolve_s && take_s) begin
         brTakenCnt_r  <= (brTakenCnt_r == 16'hFFFF) ? brTakenCnt_r : brTakenCnt_r + 16'd1;
      end else if (condResolve_s) begin
         brNtakenCnt_r <= (brNtakenCnt_r == 16'hFFFF) ? brNtakenCnt_r : brNtakenCnt_r + 16'd1;
      end else begin
         brTakenCnt_r  <= brTakenCnt_r;
         brNtakenCnt_r <= brNtakenCnt_r;
      end
   end

   assign br_taken_cnt  = brTakenCnt_r;
   assign br_ntaken_cnt = brNtakenCnt_r;
`else
   logic unusedKind_s;
   assign unusedKind_s = ^kind_s;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus randomized
// traffic against a rule-level reference model (stats checked with PC_BRANCH_STATS_EN).
module tb_pc_branch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall, instr_valid, jump, immType;
   logic        branchEq, branchNeq, branchLt, branchGt, branchLte, branchGte;
   logic [15:0] instr_pc, rs_val, rt_val;
   logic [7:0]  imm_offset;
   logic [15:0] pc;
   logic        fetch_valid, flush, taken, multi_err;
   logic [15:0] brTakenCnt, brNtakenCnt;

   int nVec = 0;
   int nErr = 0;

   // reference model: architectural view after each clock edge
   logic [15:0] mPc;
   bit          mFv, mFlush, mTaken, mErr, mBoot, mSquash;
   int          mTc, mNc;

   always #5 clock = ~clock;

   pc_branch_unit dut (
      .clock       (clock),
      .reset       (reset),
      .stall       (stall),
      .instr_valid (instr_valid),
      .instr_pc    (instr_pc),
      .branchEq    (branchEq),
      .branchNeq   (branchNeq),
      .branchLt    (branchLt),
      .branchGt    (branchGt),
      .branchLte   (branchLte),
      .branchGte   (branchGte),
      .jump        (jump),
      .immType     (immType),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .imm_offset  (imm_offset),
      .pc          (pc),
      .fetch_valid (fetch_valid),
      .flush       (flush),
      .taken       (taken),
      .multi_err   (multi_err)
`ifdef PC_BRANCH_STATS_EN
     ,.br_taken_cnt  (brTakenCnt),
      .br_ntaken_cnt (brNtakenCnt)
`endif
   );

`ifndef PC_BRANCH_STATS_EN
   assign brTakenCnt  = 16'd0;
   assign brNtakenCnt = 16'd0;
`endif

   task automatic model_reset();
      mPc = 16'h0000; mFv = 0; mFlush = 0; mTaken = 0; mErr = 0;
      mBoot = 1; mSquash = 0; mTc = 0; mNc = 0;
   endtask

   task automatic idle_inputs();
      stall = 0; instr_valid = 0; jump = 0; immType = 0;
      branchEq = 0; branchNeq = 0; branchLt = 0; branchGt = 0; branchLte = 0; branchGte = 0;
      instr_pc = 16'h0000; rs_val = 16'h0000; rt_val = 16'h0000; imm_offset = 8'h00;
   endtask

   // advance one clock and apply the architectural rules to the model
   task automatic cycle();
      bit                 st[7];
      int                 first, cnt;
      bit                 tk;
      logic [15:0]        tgt;
      logic signed [15:0] off, a, b;
      @(posedge clock);
      if (!reset) begin
         if (mBoot) begin
            mBoot = 0; mFlush = 0; mFv = !stall;
         end else if (mSquash) begin
            mSquash = 0; mFlush = 0; mFv = !stall;
            if (!stall) mPc = mPc + 16'd1;
         end else begin
            tk = 0; tgt = mPc;
            if (instr_valid) begin
               st = '{jump, branchEq, branchNeq, branchLt, branchGt, branchLte, branchGte};
               first = -1; cnt = 0;
               for (int i = 0; i < 7; i++) begin
                  if (st[i]) begin
                     cnt++;
                     if (first < 0) first = i;
                  end
               end
               if (cnt > 1) mErr = 1;
               a = rs_val; b = rt_val; off = $signed(imm_offset);
               case (first)
                  0: tk = 1;
                  1: tk = (a == b);
                  2: tk = (a != b);
                  3: tk = (a < b);
                  4: tk = (a > b);
                  5: tk = (a <= b);
                  6: tk = (a >= b);
                  default: tk = 0;
               endcase
               mTaken = tk;
               tgt = (first == 0 && !immType) ? rs_val : instr_pc + off;
               if (first >= 1 && tk && mTc < 65535) mTc++;
               if (first >= 1 && !tk && mNc < 65535) mNc++;
            end
            if (tk) begin
               mPc = tgt; mFlush = 1; mFv = 1; mSquash = 1;
            end else begin
               mFlush = 0; mFv = !stall;
               if (!stall) mPc = mPc + 16'd1;
            end
         end
      end
      #2;
   endtask

   task automatic test_reset();
      idle_inputs();
      model_reset();
      reset = 1'b1;
      #12;
      nVec++;
      if ({pc, fetch_valid, flush, taken, multi_err} !== {16'h0000, 4'b0000}) begin
         nErr++;
         $display("FAIL reset_state: got pc=%h fv=%b fl=%b tk=%b err=%b, want pc=0000 fv=0 fl=0 tk=0 err=0",
                  pc, fetch_valid, flush, taken, multi_err);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      nVec++;
      if ({pc, fetch_valid} !== {16'h0000, 1'b0}) begin
         nErr++;
         $display("FAIL boot_cycle: got pc=%h fv=%b, want pc=0000 fv=0", pc, fetch_valid);
      end
      for (int i = 0; i < 4; i++) begin
         cycle();
         nVec++;
         if ({pc, fetch_valid} !== {16'(i), 1'b1} || {pc, fetch_valid, flush, taken, multi_err} !== {mPc, mFv, mFlush, mTaken, mErr}) begin
            nErr++;
            $display("FAIL seq_fetch[%0d]: got pc=%h fv=%b fl=%b tk=%b err=%b, want pc=%h fv=1 fl=%b tk=%b err=%b",
                     i, pc, fetch_valid, flush, taken, multi_err, 16'(i), mFlush, mTaken, mErr);
         end
      end
   endtask

   task automatic test_branch_eq();
      idle_inputs();
      instr_valid = 1; branchEq = 1; rs_val = 16'd5; rt_val = 16'd5;
      instr_pc = 16'h0010; imm_offset = 8'hFC;
      cycle();
      nVec++;
      if ({pc, flush, taken} !== {16'h000C, 2'b11} || pc !== mPc) begin
         nErr++;
         $display("FAIL beq_taken: got pc=%h fl=%b tk=%b, want pc=000C fl=1 tk=1 (model pc=%h)", pc, flush, taken, mPc);
      end
      // wrong-path instruction in the flush cycle must be ignored
      branchEq = 0; jump = 1; immType = 0; rs_val = 16'h4444;
      cycle();
      nVec++;
      if ({pc, flush, fetch_valid} !== {16'h000D, 2'b01} || pc !== mPc) begin
         nErr++;
         $display("FAIL beq_squash: got pc=%h fl=%b fv=%b, want pc=000D fl=0 fv=1", pc, flush, fetch_valid);
      end
      idle_inputs();
      cycle();
      nVec++;
      if (pc !== 16'h000E || pc !== mPc) begin
         nErr++;
         $display("FAIL beq_resume: got pc=%h, want pc=000E", pc);
      end
   endtask

   task automatic test_signed();
      idle_inputs();
      instr_valid = 1; branchLt = 1; rs_val = 16'hFFFF; rt_val = 16'h0001;
      instr_pc = 16'h0020; imm_offset = 8'h08;
      cycle();
      nVec++;
      if ({pc, taken, flush} !== {16'h0028, 2'b11}) begin
         nErr++;
         $display("FAIL blt_signed: got pc=%h tk=%b fl=%b, want pc=0028 tk=1 fl=1", pc, taken, flush);
      end
      idle_inputs();
      cycle();
      instr_valid = 1; branchGt = 1; rs_val = 16'hFFFF; rt_val = 16'h0001;
      instr_pc = 16'h0020; imm_offset = 8'h08;
      cycle();
      nVec++;
      if ({pc, taken, flush} !== {16'h002A, 2'b00} || {pc, taken} !== {mPc, mTaken}) begin
         nErr++;
         $display("FAIL bgt_signed: got pc=%h tk=%b fl=%b, want pc=002A tk=0 fl=0", pc, taken, flush);
      end
   endtask

   task automatic test_jump();
      idle_inputs();
      instr_valid = 1; jump = 1; immType = 0; rs_val = 16'h1234; stall = 1;
      cycle();
      nVec++;
      if ({pc, fetch_valid, flush, taken} !== {16'h1234, 3'b111}) begin
         nErr++;
         $display("FAIL jr_over_stall: got pc=%h fv=%b fl=%b tk=%b, want pc=1234 fv=1 fl=1 tk=1", pc, fetch_valid, flush, taken);
      end
      idle_inputs();
      cycle();
      nVec++;
      if (pc !== 16'h1235 || pc !== mPc) begin
         nErr++;
         $display("FAIL jr_after: got pc=%h, want pc=1235", pc);
      end
      instr_valid = 1; jump = 1; immType = 1; instr_pc = 16'hFFFE; imm_offset = 8'h05;
      cycle();
      nVec++;
      if ({pc, flush} !== {16'h0003, 1'b1} || pc !== mPc) begin
         nErr++;
         $display("FAIL jimm_wrap: got pc=%h fl=%b, want pc=0003 fl=1", pc, flush);
      end
   endtask

   task automatic test_multi();
      idle_inputs();
      cycle();
      nVec++;
      if (multi_err !== 1'b0) begin
         nErr++;
         $display("FAIL multi_pre: got err=%b, want err=0", multi_err);
      end
      instr_valid = 1; branchEq = 1; branchNeq = 1; rs_val = 16'd1; rt_val = 16'd2;
      instr_pc = 16'h0100; imm_offset = 8'h10;
      cycle();
      nVec++;
      if ({multi_err, taken, flush} !== 3'b100 || {pc, taken} !== {mPc, mTaken}) begin
         nErr++;
         $display("FAIL multi_prio: got err=%b tk=%b fl=%b pc=%h, want err=1 tk=0 fl=0 pc=%h", multi_err, taken, flush, pc, mPc);
      end
      idle_inputs();
      for (int i = 0; i < 3; i++) cycle();
      nVec++;
      if (multi_err !== 1'b1) begin
         nErr++;
         $display("FAIL multi_sticky: got err=%b, want err=1", multi_err);
      end
   endtask

   task automatic test_random();
      int r;
      logic [6:0] s;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r < 3) s = 7'd0;
         else if (r < 9) s = 7'(1 << $urandom_range(0, 6));
         else s = 7'($urandom);
         {jump, branchEq, branchNeq, branchLt, branchGt, branchLte, branchGte} = s;
         immType     = 1'($urandom);
         instr_valid = ($urandom_range(0, 3) != 0);
         stall       = ($urandom_range(0, 3) == 0);
         instr_pc    = 16'($urandom);
         imm_offset  = 8'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            rs_val = 16'($urandom_range(0, 4)) - 16'd2;
            rt_val = 16'($urandom_range(0, 4)) - 16'd2;
         end else begin
            rs_val = 16'($urandom);
            rt_val = 16'($urandom);
         end
         cycle();
         nVec++;
         if ({pc, fetch_valid, flush, taken, multi_err} !== {mPc, mFv, mFlush, mTaken, mErr}) begin
            nErr++;
            $display("FAIL random[%0d]: got pc=%h fv=%b fl=%b tk=%b err=%b, want pc=%h fv=%b fl=%b tk=%b err=%b",
                     n, pc, fetch_valid, flush, taken, multi_err, mPc, mFv, mFlush, mTaken, mErr);
         end
`ifdef PC_BRANCH_STATS_EN
         nVec++;
         if ({brTakenCnt, brNtakenCnt} !== {16'(mTc), 16'(mNc)}) begin
            nErr++;
            $display("FAIL random_cnt[%0d]: got %0d/%0d, want %0d/%0d", n, brTakenCnt, brNtakenCnt, mTc, mNc);
         end
`endif
      end
   endtask

   task automatic test_reset_in_flush();
      idle_inputs();
      cycle();
      cycle();
      instr_valid = 1; jump = 1; immType = 1; instr_pc = 16'h0100; imm_offset = 8'h10;
      cycle();
      nVec++;
      if ({pc, flush, taken} !== {16'h0110, 2'b11}) begin
         nErr++;
         $display("FAIL rif_enter: got pc=%h fl=%b tk=%b, want pc=0110 fl=1 tk=1", pc, flush, taken);
      end
      idle_inputs();
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      nVec++;
      if ({pc, fetch_valid, flush, taken, multi_err} !== {16'h0000, 4'b0000}) begin
         nErr++;
         $display("FAIL rif_async: got pc=%h fv=%b fl=%b tk=%b err=%b, want pc=0000 fv=0 fl=0 tk=0 err=0",
                  pc, fetch_valid, flush, taken, multi_err);
      end
      @(negedge clock);
      reset = 1'b0;
      cycle();
      nVec++;
      if ({pc, fetch_valid, flush} !== {16'h0000, 2'b10}) begin
         nErr++;
         $display("FAIL rif_reboot: got pc=%h fv=%b fl=%b, want pc=0000 fv=1 fl=0", pc, fetch_valid, flush);
      end
   endtask

`ifdef PC_BRANCH_STATS_EN
   task automatic test_stats();
      logic [2:0] kinds[5]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      logic [15:0] rsv[5]   = '{16'd3, 16'd1, 16'd4, 16'd5, 16'hFFFF};
      logic [15:0] rtv[5]   = '{16'd3, 16'd2, 16'd4, 16'd3, 16'd0};
      nVec++;
      if ({brTakenCnt, brNtakenCnt} !== 32'd0) begin
         nErr++;
         $display("FAIL stats_clear: got %0d/%0d, want 0/0", brTakenCnt, brNtakenCnt);
      end
      for (int i = 0; i < 5; i++) begin
         idle_inputs();
         instr_valid = 1; rs_val = rsv[i]; rt_val = rtv[i]; instr_pc = 16'h0040; imm_offset = 8'h04;
         case (kinds[i])
            3'd0: branchEq = 1;
            3'd1: branchNeq = 1;
            3'd2: branchGte = 1;
            3'd3: branchLt = 1;
            default: branchGt = 1;
         endcase
         cycle();
         idle_inputs();
         cycle();
      end
      nVec++;
      if ({brTakenCnt, brNtakenCnt} !== {16'd3, 16'd2} || {brTakenCnt, brNtakenCnt} !== {16'(mTc), 16'(mNc)}) begin
         nErr++;
         $display("FAIL stats_count: got %0d/%0d, want 3/2", brTakenCnt, brNtakenCnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_branch_eq();
      test_signed();
      test_jump();
      test_multi();
      test_random();
      test_reset_in_flush();
`ifdef PC_BRANCH_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
